// File: rtl/icache_miss_ctrl.sv
// rtl/icache_miss_ctrl.sv - direct-mapped instruction cache with miss/refill controller
// Hits return a word in the same cycle; misses stall, fetch a 128-bit line, install it and replay.
module icache_miss_ctrl #(
   parameter int INDEX_W = 4,
   parameter int LINE_W  = 128,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_instr,
   output logic              fetch_valid,
   output logic              stall,
   input  logic              flush,
   output logic              mem_req,
   output logic [31:0]       mem_addr,
   input  logic              mem_ack,
   input  logic [LINE_W-1:0] mem_line,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int LINES = 2**INDEX_W;
   localparam int TAG_W = 28 - INDEX_W;

   typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL} state_t;
   state_t state, state_next;

   logic [LINES-1:0]   valid;
   logic [TAG_W-1:0]   tag_arr  [LINES];
   logic [LINE_W-1:0]  data_arr [LINES];
   logic [27:0]        miss_line;

   logic [INDEX_W-1:0] idx, miss_idx;
   logic [TAG_W-1:0]   tag;
   logic [1:0]         word;
   logic               hit, miss_start, refill_done;
   logic               unused_ok;

   assign word      = fetch_addr[3:2];
   assign idx       = fetch_addr[4 +: INDEX_W];
   assign tag       = fetch_addr[31 -: TAG_W];
   assign miss_idx  = miss_line[0 +: INDEX_W];
   assign unused_ok = ^fetch_addr[1:0];
   assign hit       = fetch_req & valid[idx] & (tag_arr[idx] == tag);

   always_comb begin
      state_next  = state;
      fetch_valid = 1'b0;
      fetch_instr = '0;
      stall       = 1'b0;
      miss_start  = 1'b0;
      refill_done = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_req) begin
               if (hit) begin
                  fetch_valid = 1'b1;
                  fetch_instr = data_arr[idx][{word, 5'b0} +: 32];
               end else begin
                  stall      = 1'b1;
                  miss_start = 1'b1;
                  state_next = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            stall = 1'b1;
            if (mem_ack) begin
               refill_done = 1'b1;
               state_next  = REFILL;
            end
         end
         REFILL: begin
            stall      = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         valid     <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         miss_cnt  <= '0;
         miss_line <= '0;
      end else begin
         state <= state_next;
         // refill install is ordered after flush so it survives a coincident flush
         if (flush)
            valid <= '0;
         if (refill_done) begin
            valid[miss_idx] <= 1'b1;
            mem_req         <= 1'b0;
         end
         if (miss_start) begin
            miss_line <= fetch_addr[31:4];
            mem_req   <= 1'b1;
            mem_addr  <= {fetch_addr[31:4], 4'b0};
            if (miss_cnt != '1)
               miss_cnt <= miss_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (refill_done) begin
         tag_arr[miss_idx]  <= miss_line[27 -: TAG_W];
         data_arr[miss_idx] <= mem_line;
      end
   end
endmodule

// File: tb/tb_icache_miss_ctrl.sv
// tb/tb_icache_miss_ctrl.sv - table-driven scoreboard bench for icache_miss_ctrl
module tb_icache_miss_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         fetch_req;
   logic [31:0]  fetch_addr;
   logic [31:0]  fetch_instr;
   logic         fetch_valid;
   logic         stall;
   logic         flush;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ack;
   logic [127:0] mem_line;
   logic [15:0]  miss_cnt;

   logic flush_main = 1'b0, flush_resp = 1'b0;
   logic ack_main = 1'b0, ack_resp = 1'b0;
   int   ack_delay = 1;
   bit   flush_at_ack = 1'b0;
   int   errors = 0, checks = 0;
   logic [31:0] sb_q[$];

   assign flush   = flush_main | flush_resp;
   assign mem_ack = ack_main | ack_resp;

   icache_miss_ctrl #(.INDEX_W(4), .LINE_W(128), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_instr(fetch_instr), .fetch_valid(fetch_valid), .stall(stall),
      .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_line(mem_line), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model_line(input logic [31:0] a);
      logic [127:0] l;
      if (a[31:4] == 28'h10)
         l = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      else
         for (int i = 0; i < 4; i++)
            l[i*32 +: 32] = {a[31:4], 2'(i), 2'b00} ^ 32'hA5A50000;
      return l;
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [127:0] l;
      l = model_line(a);
      return l[a[3:2]*32 +: 32];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // memory model: acks on the ack_delay-th cycle of a request
   initial begin
      int cnt;
      cnt = 0;
      mem_line = '0;
      forever begin
         @(negedge clk);
         ack_resp   = 1'b0;
         flush_resp = 1'b0;
         if (mem_req) begin
            cnt++;
            if (cnt == ack_delay) begin
               ack_resp   = 1'b1;
               flush_resp = flush_at_ack;
               mem_line   = model_line(mem_addr);
               cnt        = 0;
            end
         end else
            cnt = 0;
      end
   end

   task automatic do_access(input logic [31:0] a, input bit exp_hit, input int dly,
                            input int exp_cnt, input bit fl);
      int  cyc, reqc;
      bit  got;
      ack_delay = dly;
      @(posedge clk); #1;
      fetch_req  = 1'b1;
      fetch_addr = a;
      flush_main = fl;
      sb_q.push_back(model_word(a));
      @(negedge clk);
      check("hit_now", 32'(fetch_valid), 32'(exp_hit));
      check("stall_now", 32'(stall), 32'(!exp_hit));
      check("no_req_now", 32'(mem_req), 32'd0);
      got  = fetch_valid;
      cyc  = 0;
      reqc = 0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         flush_main = 1'b0;
         @(negedge clk);
         cyc++;
         if (mem_req) begin
            reqc++;
            check("mem_addr", mem_addr, {a[31:4], 4'b0});
         end
         if (fetch_valid) got = 1'b1;
         else check("stall_hold", 32'(stall), 32'd1);
      end
      check("got_valid", 32'(got), 32'd1);
      if (!exp_hit) begin
         check("latency", 32'(cyc), 32'(dly + 2));
         check("req_cycles", 32'(reqc), 32'(dly));
      end
      if (got) check("fetch_instr", fetch_instr, sb_q.pop_front());
      else void'(sb_q.pop_front());
      check("miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
      @(posedge clk); #1;
      fetch_req  = 1'b0;
      flush_main = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      int          dly;
      int          cnt;
   } vec_t;
   vec_t tbl[10];

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{32'h104, 1'b0, 1, 1};
      tbl[1] = '{32'h100, 1'b1, 1, 1};
      tbl[2] = '{32'h108, 1'b1, 1, 1};
      tbl[3] = '{32'h10C, 1'b1, 1, 1};
      tbl[4] = '{32'h200, 1'b0, 1, 2};
      tbl[5] = '{32'h100, 1'b0, 1, 3};
      tbl[6] = '{32'h204, 1'b0, 2, 4};
      tbl[7] = '{32'h3F8, 1'b0, 5, 5};
      tbl[8] = '{32'h3F4, 1'b1, 1, 5};
      tbl[9] = '{32'h208, 1'b1, 1, 5};

      rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
      #1;
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_cnt", 32'(miss_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 10; i++)
         do_access(tbl[i].addr, tbl[i].hit, tbl[i].dly, tbl[i].cnt, 1'b0);

      // flush: lookup in the flush cycle still hits, the next one misses
      do_access(32'h100, 1'b0, 1, 6, 1'b0);
      do_access(32'h104, 1'b1, 1, 6, 1'b1);
      do_access(32'h100, 1'b0, 1, 7, 1'b0);

      // flush coincident with mem_ack: refilled line survives, others are gone
      flush_at_ack = 1'b1;
      do_access(32'h500, 1'b0, 1, 8, 1'b0);
      flush_at_ack = 1'b0;
      do_access(32'h504, 1'b1, 1, 8, 1'b0);
      do_access(32'h3F4, 1'b0, 1, 9, 1'b0);

      // reset in MISS_REQ, then a late ack
      ack_delay = 1000;
      @(posedge clk); #1;
      fetch_req = 1'b1; fetch_addr = 32'h600;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_req_up", 32'(mem_req), 32'd1);
      #2 rst = 1'b1; fetch_req = 1'b0;
      #1;
      check("mid_rst_req", 32'(mem_req), 32'd0);
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_cnt", 32'(miss_cnt), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk) ack_main = 1'b1;
      @(negedge clk) ack_main = 1'b0;
      check("late_ack_req", 32'(mem_req), 32'd0);
      check("late_ack_stall", 32'(stall), 32'd0);
      do_access(32'h600, 1'b0, 1, 1, 1'b0);
      do_access(32'h104, 1'b0, 1, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
